mc_fsm: RTL and testbench
=========================

MC_FSM -- requirements
Module: mc_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 Op  in  2  instruction[27:26]; Funct  in  6  instruction[25:20]; Rd  in  4  instruction[15:12]; Cond  in  4  instruction[31:28].
REQ-005 ALUFlags  in  4  NZCV from the ALU, combinational in the current cycle.
REQ-006 MemReady  in  1  memory access complete; present only with MC_FSM_WAIT_EN.
REQ-007 IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc  out  1 each  write enables and address mux select.
REQ-008 ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc  out  2 each  datapath mux selects and ALU operation.
REQ-009 State  out  4  current state encoding, for debug only.

Function
REQ-010 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-011 The FSM SHALL make these transitions:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECR; Op=00 with Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH (undefined, no side effects).
- MEMADR: Funct[0]=1->MEMRD, else MEMWR.
- MEMRD->MEMWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH; EXECR, EXECI->ALUWB.
- Codes 10-15: ->FETCH.
REQ-012 FETCH SHALL drive IRWrite=1, AdrSrc=0, ALUSrcA=01 (PC), ALUSrcB=10 (constant 4), ALUControl=00 (add), ResultSrc=10 (ALU output) and PCWrite=1.
REQ-013 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (forms PC+8) and RegSrc per Op (branch: RegSrc[0]=1; store: RegSrc[1]=1).
REQ-014 MEMADR, EXECI and BRANCH SHALL drive ALUSrcB=01 (immediate), with ImmSrc = 01 (memory), 00 (data-processing) or 10 (branch) respectively; EXECR SHALL drive ALUSrcB=00.
REQ-015 MEMRD and MEMWR SHALL drive AdrSrc=1; MEMWB SHALL drive ResultSrc=01 (read data); ALUWB SHALL drive ResultSrc=00 (ALUOut).
REQ-016 ALUControl in EXECR/EXECI SHALL decode Funct[4:1]: 0100->00 ADD, 0010->01 SUB, 0000->10 AND, 1100->11 ORR; all other values and all other states SHALL give 00.
REQ-017 CondEx SHALL be evaluated from Cond and the internal NZCV register using the ARM codes EQ..AL (0000-1110); 1111 SHALL give CondEx=0.
REQ-018 RegWrite in MEMWB/ALUWB, MemWrite in MEMWR and PCWrite in BRANCH SHALL be asserted only when CondEx=1; FETCH writes are unconditional.
REQ-019 When Rd=15 and a write-back occurs in MEMWB or ALUWB with CondEx=1, the block SHALL assert PCWrite with RegWrite=0.
REQ-020 The NZCV register SHALL update at the end of EXECR/EXECI only when Funct[0]=1 and CondEx=1:
- NZ always;
- CV only for ADD/SUB.
REQ-021 CondEx SHALL use flags registered before the current instruction; a flag update and its evaluation in the same cycle SHALL NOT forward.

Reset
REQ-022 While RESET_N=0, the block SHALL force State=FETCH and NZCV=0000, drive every write enable to 0 and drive every select to 00.
REQ-023 The first rising edge after RESET_N deassertion SHALL execute FETCH.
REQ-024 Reset asserted mid-instruction SHALL abort the instruction with no further write enables.

Configuration
REQ-025 With MC_FSM_WAIT_EN defined, the MemReady port SHALL exist and memory states SHALL wait:
- FETCH holds and asserts IRWrite/PCWrite only in the cycle MemReady=1;
- MEMRD holds until MemReady=1;
- MEMWR holds MemWrite high until MemReady=1.
REQ-026 With MC_FSM_WAIT_EN undefined, the MemReady port SHALL be absent and every state SHALL last exactly one cycle.

Structure
REQ-027 State encodings, ALUControl codes and mux-select constants SHALL live in the shared package mc_pkg.
REQ-028 Condition evaluation SHALL be the sub-module mc_condcheck (Cond and NZCV in, CondEx out, purely combinational).

Verification
REQ-029 Reset: hold RESET_N=0 for 3 cycles, then release -> State=0 and IRWrite=1 in the first cycle; all write enables=0 during reset.
REQ-030 ADD R1,R2,R3 (Op=00, Funct=001000, Cond=1110) -> states 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=00 in state 6.
REQ-031 SUBS with equal operands (ALUFlags=0100) followed by BNE (Cond=0001) -> Z=1 is latched and PCWrite=0 in BRANCH; the same sequence with BEQ -> PCWrite=1.
REQ-032 LDR into Rd=15 -> states 0,1,2,3,4; PCWrite=1 and RegWrite=0 in MEMWB.
REQ-033 With MC_FSM_WAIT_EN: STR with MemReady low for 2 cycles -> MEMWR lasts 3 cycles with MemWrite=1 throughout, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// ALU operation codes, datapath mux-select constants and the ALU decode helper.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // Instruction class (Op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALU source A
  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  // ALU source B
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate extension
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Data-processing command (Funct[4:1]) to ALU operation
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  // Only arithmetic commands produce meaningful carry/overflow
  function automatic logic is_addsub(input logic [3:0] cmd);
    is_addsub = (cmd == 4'b0100) || (cmd == 4'b0010);
  endfunction

endpackage

// File: rtl/mc_condcheck.sv
// ARM condition-code evaluation: Cond field against registered NZCV flags.
// Purely combinational; code 1111 never executes.
module mc_condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Condition table EQ..AL
  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_fsm.sv
// Multicycle ARM-subset main controller (Moore FSM).
// Optional build macro MC_FSM_WAIT_EN adds the MemReady port and makes
// FETCH, MEMRD and MEMWR hold until memory signals completion.
module mc_fsm
  import mc_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
`ifdef MC_FSM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  state_t     state;
  logic [3:0] nzcv;
  logic       condex_now;
  logic       condex_q;
  logic       mem_ready;

`ifdef MC_FSM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  mc_condcheck u_cond (
    .cond   (Cond),
    .nzcv   (nzcv),
    .condex (condex_now)
  );

  assign State = state;

  // Condition is captured in DECODE from the flags preceding this instruction,
  // so a flag update in EXECR/EXECI cannot change the outcome of its own write-back.
  // State, flag register and latched condition update
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= FETCH;
      nzcv     <= '0;
      condex_q <= 1'b0;
    end else begin
      if (state == DECODE) condex_q <= condex_now;
      if ((state == EXECR || state == EXECI) && Funct[0] && condex_q) begin
        nzcv[3:2] <= ALUFlags[3:2];
        if (is_addsub(Funct[4:1])) nzcv[1:0] <= ALUFlags[1:0];
      end
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:  state <= MEMADR;
            OP_DP:   state <= Funct[5] ? EXECI : EXECR;
            OP_BR:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:  state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) state <= MEMWB;
        MEMWR:   if (mem_ready) state <= FETCH;
        EXECR,
        EXECI:   state <= ALUWB;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from the current state only (plus the instruction
  // fields the state needs) and forced to zero while reset is held.
  // Moore output decode
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_DP;
    RegSrc     = '0;
    case (state)
      FETCH: begin
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        RegSrc    = {(Op == OP_MEM) && !Funct[0], Op == OP_BR};
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_MEM;
      end
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_RDATA;
        PCWrite   = condex_q && (Rd == 4'd15);
        RegWrite  = condex_q && (Rd != 4'd15);
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
      end
      EXECR:  ALUControl = alu_decode(Funct[4:1]);
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_DP;
        ALUControl = alu_decode(Funct[4:1]);
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        PCWrite   = condex_q && (Rd == 4'd15);
        RegWrite  = condex_q && (Rd != 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_BR;
        ResultSrc = RES_ALU;
        PCWrite   = condex_q;
      end
      default: ;
    endcase
    if (!RESET_N) begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ResultSrc  = '0;
      ALUControl = '0;
      ImmSrc     = '0;
      RegSrc     = '0;
    end
  end

endmodule

// File: tb/tb_mc_fsm.sv
// Scoreboard bench for mc_fsm: the driver issues whole instructions, a
// reference model expands each into its expected per-cycle outputs and queues
// them; a monitor on the falling edge pops and compares.
module tb_mc_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;

  typedef logic [20:0] vec_t;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
`ifdef MC_FSM_WAIT_EN
  logic       MemReady;
`endif
  logic       IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  vec_t exp_q[$];
  vec_t mon_exp, mon_act;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic fn, fz, fc, fv;   // reference flag state

  mc_fsm dut (
    .CLK(CLK), .RESET_N(RESET_N), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags),
`ifdef MC_FSM_WAIT_EN
    .MemReady(MemReady),
`endif
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  always #5 CLK = ~CLK;

  // ARM condition semantics on the reference flags
  function automatic logic cond_ok(input logic [3:0] c);
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [5:0] f);
    logic [3:0] cmd;
    cmd = f[4:1];
    if (cmd == 4'b0100) return 2'b00;
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic is_mem_state(input int st);
    return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  endfunction

  // Expected output vector for one cycle spent in state st
  function automatic vec_t exp_vec(input int st, input logic [1:0] op, input logic [5:0] f,
                                   input logic [3:0] rd, input logic ce, input logic rdy);
    logic ire, pcw, rw, mw, adr;
    logic [1:0] a, b, res, alu, imm, rs;
    logic [3:0] s4;
    s4 = st[3:0];
    {ire, pcw, rw, mw, adr} = '0;
    {a, b, res, alu, imm, rs} = '0;
    case (st)
      S_FETCH:  begin ire = rdy; pcw = rdy; a = 2'b01; b = 2'b10; res = 2'b10; end
      S_DECODE: begin
        a = 2'b01; b = 2'b10; res = 2'b10;
        rs[0] = (op == 2'b10);
        rs[1] = (op == 2'b01) && !f[0];
      end
      S_MEMADR: begin b = 2'b01; imm = 2'b01; end
      S_MEMRD:  adr = 1'b1;
      S_MEMWB:  begin res = 2'b01; if (rd == 4'd15) pcw = ce; else rw = ce; end
      S_MEMWR:  begin adr = 1'b1; mw = ce; end
      S_EXECR:  alu = alu_code(f);
      S_EXECI:  begin b = 2'b01; imm = 2'b00; alu = alu_code(f); end
      S_ALUWB:  begin res = 2'b00; if (rd == 4'd15) pcw = ce; else rw = ce; end
      S_BRANCH: begin b = 2'b01; imm = 2'b10; res = 2'b10; pcw = ce; end
      default: ;
    endcase
    return {s4, ire, pcw, rw, mw, adr, a, b, res, alu, imm, rs};
  endfunction

  // One clock cycle in state st: drive ready, queue expectation, advance
  task automatic one_cycle(input int st, input logic ce, input logic rdy);
    logic r;
    r = 1'b1;
`ifdef MC_FSM_WAIT_EN
    if (is_mem_state(st)) begin
      MemReady = rdy;
      r = rdy;
    end else begin
      MemReady = 1'($urandom_range(0, 1));
    end
`endif
    exp_q.push_back(exp_vec(st, Op, Funct, Rd, ce, r));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    RESET_N = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back('0);
      @(posedge CLK);
      #1;
    end
    RESET_N = 1'b1;
    {fn, fz, fc, fv} = '0;
  endtask

  // Issue one instruction; abort_at >= 0 stops before that step (caller resets)
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input logic [3:0] c, input logic [3:0] flg,
                           input int abort_at, input int waits);
    int seq[$];
    logic ce;
    int wt;
`ifdef MC_FSM_WAIT_EN
    wt = waits;
`else
    wt = 0 * waits;
`endif
    Op = op; Funct = f; Rd = rd; Cond = c; ALUFlags = flg;
    ce = cond_ok(c);
    seq = {S_FETCH, S_DECODE};
    case (op)
      2'b00: begin
        seq.push_back(f[5] ? S_EXECI : S_EXECR);
        seq.push_back(S_ALUWB);
      end
      2'b01: begin
        seq.push_back(S_MEMADR);
        if (f[0]) begin seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
        else seq.push_back(S_MEMWR);
      end
      2'b10: seq.push_back(S_BRANCH);
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) return;
      if (is_mem_state(seq[i]))
        for (int w = 0; w < wt; w++) one_cycle(seq[i], ce, 1'b0);
      one_cycle(seq[i], ce, 1'b1);
    end
    if (op == 2'b00 && f[0] && ce) begin
      fn = flg[3];
      fz = flg[2];
      if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) begin
        fc = flg[1];
        fv = flg[0];
      end
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {State, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got state=%0d vec=%h, required state=%0d vec=%h",
                 $time, mon_act[20:17], mon_act, mon_exp[20:17], mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0;
    Op = '0; Funct = '0; Rd = '0; Cond = '0; ALUFlags = '0;
`ifdef MC_FSM_WAIT_EN
    MemReady = 1'b0;
`endif
    {fn, fz, fc, fv} = '0;
    @(posedge CLK);
    #1;
    do_reset(3);

    // ADD R1,R2,R3
    run_instr(2'b00, 6'b001000, 4'd1, 4'hE, 4'b0000, -1, 0);
    // SUBS equal operands, then BNE (not taken)
    run_instr(2'b00, 6'b000101, 4'd2, 4'hE, 4'b0100, -1, 0);
    run_instr(2'b10, 6'b000000, 4'd0, 4'h1, 4'b0000, -1, 0);
    // SUBS equal operands, then BEQ (taken)
    run_instr(2'b00, 6'b000101, 4'd2, 4'hE, 4'b0100, -1, 0);
    run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, -1, 0);
    // LDR into PC
    run_instr(2'b01, 6'b011001, 4'd15, 4'hE, 4'b0000, -1, 1);
    // Clear Z, then ADDS NE producing Z=1: write-back still uses pre-instruction flags
    run_instr(2'b00, 6'b001001, 4'd3, 4'hE, 4'b0000, -1, 0);
    run_instr(2'b00, 6'b001001, 4'd4, 4'h1, 4'b0100, -1, 0);
    run_instr(2'b00, 6'b001000, 4'd5, 4'h1, 4'b0000, -1, 0);
    // STR with two not-ready cycles in MEMWR (no-op waits in default build)
    run_instr(2'b01, 6'b011000, 4'd3, 4'hE, 4'b0000, -1, 2);
    // Undefined Op, never-condition, ORR immediate
    run_instr(2'b11, 6'b111111, 4'd7, 4'hE, 4'b1111, -1, 0);
    run_instr(2'b00, 6'b111001, 4'd6, 4'hF, 4'b1111, -1, 0);
    run_instr(2'b00, 6'b111001, 4'd6, 4'hE, 4'b1010, -1, 0);
    // Reset in the middle of a write-back instruction
    run_instr(2'b00, 6'b001001, 4'd8, 4'hE, 4'b1111, 3, 0);
    do_reset(2);
    run_instr(2'b00, 6'b001000, 4'd8, 4'h0, 4'b0000, -1, 0);

    for (int k = 0; k < 150; k++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd, c, flg;
      int ab;
      op  = 2'($urandom_range(0, 3));
      f   = 6'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      c   = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      flg = 4'($urandom);
      ab  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_instr(op, f, rd, c, flg, ab, int'($urandom_range(0, 2)));
      if (ab >= 0) do_reset(1);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
